// File: rtl/frame_timing_ctrl_if.sv
// rtl/frame_timing_ctrl_if.sv - frame/line timing bus from the controller to the pattern generator
interface frame_timing_ctrl_if;
  logic       fval;
  logic       lval;
  logic       dval;
  logic       fval_posedge;
  logic       lval_negedge;
  logic [2:0] sel;

  modport master (output fval, lval, dval, fval_posedge, lval_negedge, sel);
  modport slave  (input  fval, lval, dval, fval_posedge, lval_negedge, sel);
endinterface

// File: rtl/frame_timing_ctrl.sv
// rtl/frame_timing_ctrl.sv - camera-style fval/lval/dval generator with per-frame pattern select
module frame_timing_ctrl #(
  parameter int DVAL_HIGH          = 640,
  parameter int ROW_COUNT          = 480,
  parameter int FV_TO_LV           = 4,
  parameter int H_BLANK            = 16,
  parameter int V_BLANK            = 32,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       auto_mode,
  input  logic [2:0]                 manual_sel,
  input  logic                       sel_update,
  frame_timing_ctrl_if.master        vid,
  output logic [15:0]                frame_count,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, FV_LEAD, LINE, HBLANK, VBLANK} state_t;

  localparam logic [15:0] LEAD_LAST = 16'(FV_TO_LV - 1);
  localparam logic [15:0] PIX_LAST  = 16'(DVAL_HIGH - 1);
  localparam logic [15:0] ROW_LAST  = 16'(ROW_COUNT - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);
  localparam logic [15:0] FPP       = 16'(FRAMES_PER_PATTERN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, line_q, line_d, fip_q, fip_d, frame_count_d;
  logic [2:0]  sel_q, sel_d, pending_q, pending_d;
  logic        fval_q, lval_q, fpos_q, fpos_d, lneg_q, lneg_d, busy_q;

  // Auto sequence skips 100 and 101; any unexpected value restarts at 000.
  function automatic logic [2:0] next_pattern(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b110;
      3'b110:  n = 3'b111;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    line_d        = line_q;
    frame_count_d = frame_count;
    fpos_d        = 1'b0;
    lneg_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FV_LEAD;
          cnt_d   = '0;
          fpos_d  = 1'b1;
        end
      end
      FV_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          state_d = LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LINE: begin
        if (cnt_q == PIX_LAST) begin
          cnt_d  = '0;
          lneg_d = 1'b1;
          if (line_q == ROW_LAST) begin
            state_d       = VBLANK;
            line_d        = '0;
            frame_count_d = frame_count + 16'd1;
          end else begin
            state_d = HBLANK;
            line_d  = line_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      VBLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = FV_LEAD;
            fpos_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern select only moves on the edge that raises fval_posedge.
  always_comb begin
    sel_d     = sel_q;
    fip_d     = fip_q;
    pending_d = sel_update ? manual_sel : pending_q;
    if (fpos_d) begin
      if (auto_mode) begin
        if (fip_q >= FPP) begin
          sel_d = next_pattern(sel_q);
          fip_d = 16'd1;
        end else begin
          fip_d = fip_q + 16'd1;
        end
      end else begin
        sel_d = pending_q;
        fip_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      fip_q       <= '0;
      frame_count <= '0;
      sel_q       <= '0;
      pending_q   <= '0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      fpos_q      <= 1'b0;
      lneg_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      fip_q       <= fip_d;
      frame_count <= frame_count_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      fval_q      <= (state_d == FV_LEAD) || (state_d == LINE) || (state_d == HBLANK);
      lval_q      <= (state_d == LINE);
      fpos_q      <= fpos_d;
      lneg_q      <= lneg_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign vid.fval         = fval_q;
  assign vid.lval         = lval_q;
  assign vid.dval         = lval_q;
  assign vid.fval_posedge = fpos_q;
  assign vid.lval_negedge = lneg_q;
  assign vid.sel          = sel_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// tb/tb_frame_timing_ctrl.sv - frame-table scoreboard bench for frame_timing_ctrl
module tb_frame_timing_ctrl;
  localparam int DV = 8, ROWS = 4, LEAD = 2, HB = 2, VB = 3, FPP = 1;
  localparam int FV_LEN    = LEAD + ROWS * DV + (ROWS - 1) * HB;
  localparam int FRAME_LEN = FV_LEN + VB;
  localparam int NV = 14;

  typedef struct {
    logic       auto_m;
    int         n;
    int         p1;
    logic [2:0] s1;
    int         p2;
    logic [2:0] s2;
    logic [2:0] exp_sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        auto_mode = 1'b0;
  logic [2:0]  manual_sel = 3'b000;
  logic        sel_update = 1'b0;
  logic [15:0] frame_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int mon_idx = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_exp, mon_act;
  vec_t vecs[NV];

  frame_timing_ctrl_if vid();

  frame_timing_ctrl #(
    .DVAL_HIGH(DV), .ROW_COUNT(ROWS), .FV_TO_LV(LEAD),
    .H_BLANK(HB), .V_BLANK(VB), .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode),
    .manual_sel(manual_sel), .sel_update(sel_update), .vid(vid),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int i);
    for (int p = 0; p < FRAME_LEN; p++) begin
      logic f, l, pe, ne;
      logic [15:0] fc;
      f  = (p < FV_LEN);
      l  = (p >= LEAD) && (p < FV_LEN) && (((p - LEAD) % (DV + HB)) < DV);
      pe = (p == 0);
      ne = (p >= LEAD + DV) && (p <= FV_LEN) && (((p - LEAD - DV) % (DV + HB)) == 0);
      fc = 16'(i + ((p >= FV_LEN) ? 1 : 0));
      exp_q.push_back({f, l, l, pe, ne, 1'b1, vecs[i].exp_sel, fc});
    end
  endtask

  // Monitor: compare every DUT cycle against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {vid.fval, vid.lval, vid.dval, vid.fval_posedge, vid.lval_negedge,
                 busy, vid.sel, frame_count};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL timing_seq idx %0d actual %h expected %h (fv lv dv fpe lne busy sel fc)",
                 mon_idx, mon_act, mon_exp);
      end
      mon_idx++;
    end
  end

  initial begin
    //          auto n  p1 s1      p2 s2      exp_sel
    vecs[0]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b000};
    vecs[1]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b001};
    vecs[2]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b010};
    vecs[3]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b011};
    vecs[4]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b110};
    vecs[5]  = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b111};
    vecs[6]  = '{1'b1, 1, 20, 3'b011, 0, 3'b000, 3'b000};
    vecs[7]  = '{1'b0, 2, 5, 3'b010, 25, 3'b111, 3'b011};
    vecs[8]  = '{1'b0, 0, 0, 3'b000, 0, 3'b000, 3'b111};
    vecs[9]  = '{1'b0, 1, 18, 3'b001, 0, 3'b000, 3'b111};
    vecs[10] = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b111};
    vecs[11] = '{1'b1, 0, 0, 3'b000, 0, 3'b000, 3'b000};
    vecs[12] = '{1'b0, 1, 0, 3'b110, 0, 3'b000, 3'b001};
    vecs[13] = '{1'b0, 0, 0, 3'b000, 0, 3'b000, 3'b110};

    repeat (3) @(posedge clk);
    #1;
    check("reset_fval", int'(vid.fval), 0);
    check("reset_lval", int'(vid.lval), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_sel", int'(vid.sel), 0);
    check("reset_frame_count", int'(frame_count), 0);

    @(negedge clk);
    rst = 1'b0;
    auto_mode = vecs[0].auto_m;
    push_frame(0);
    enable = 1'b1;

    for (int i = 0; i < NV; i++) begin
      for (int p = 0; p < FRAME_LEN; p++) begin
        @(negedge clk);
        sel_update = 1'b0;
        if (p == 1 && i + 1 < NV) begin
          auto_mode = vecs[i + 1].auto_m;
          push_frame(i + 1);
        end
        if (vecs[i].n >= 1 && p == vecs[i].p1) begin
          manual_sel = vecs[i].s1;
          sel_update = 1'b1;
        end
        if (vecs[i].n >= 2 && p == vecs[i].p2) begin
          manual_sel = vecs[i].s2;
          sel_update = 1'b1;
        end
        // Drop enable during line 1 of the last frame: the frame must still complete.
        if (i == NV - 1 && p == LEAD + DV + HB + 3) begin
          enable = 1'b0;
          for (int k = 0; k < 6; k++)
            exp_q.push_back({6'b000000, vecs[NV - 1].exp_sel, 16'(NV)});
        end
      end
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    // Mid-LINE reset with enable and sel_update asserted alongside.
    @(negedge clk);
    enable = 1'b1;
    auto_mode = 1'b0;
    repeat (LEAD + 5) @(negedge clk);
    check("pre_rst_lval", int'(vid.lval), 1);
    rst = 1'b1;
    manual_sel = 3'b111;
    sel_update = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fval", int'(vid.fval), 0);
    check("rst_lval", int'(vid.lval), 0);
    check("rst_dval", int'(vid.dval), 0);
    check("rst_pulses", int'({vid.fval_posedge, vid.lval_negedge}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sel", int'(vid.sel), 0);
    check("rst_frame_count", int'(frame_count), 0);
    @(negedge clk);
    rst = 1'b0;
    sel_update = 1'b0;
    @(posedge clk);
    #1;
    check("restart_fval_posedge", int'(vid.fval_posedge), 1);
    check("restart_sel_pending_cleared", int'(vid.sel), 0);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
